// File: rtl/cla_adder_pipe_pkg.sv
// Shared constants and nibble-level CLA helpers for the pipelined add/sub unit.
// NIBBLE and LCU_SPAN match the values the ALU uses.
package cla_adder_pipe_pkg;

    localparam int unsigned NIBBLE     = 4;
    localparam int unsigned LCU_SPAN   = 4;
    localparam int unsigned GROUP_BITS = NIBBLE * LCU_SPAN;

    typedef struct packed {
        logic p;
        logic g;
    } nib_pg_t;

    // Block propagate/generate of one 4-bit cell, independent of its carry-in.
    function automatic nib_pg_t nibble_pg(input logic [NIBBLE-1:0] a,
                                          input logic [NIBBLE-1:0] b);
        logic [NIBBLE-1:0] pp;
        logic [NIBBLE-1:0] gg;
        nib_pg_t           r;
        pp  = a ^ b;
        gg  = a & b;
        r.p = &pp;
        r.g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
        return r;
    endfunction

    // Sum of one 4-bit cell; the only ripple path in the adder lives here.
    function automatic logic [NIBBLE-1:0] nibble_sum(input logic [NIBBLE-1:0] a,
                                                     input logic [NIBBLE-1:0] b,
                                                     input logic              ci);
        logic [NIBBLE-1:0] pp;
        logic [NIBBLE-1:0] gg;
        logic [NIBBLE-1:0] c;
        pp   = a ^ b;
        gg   = a & b;
        c[0] = ci;
        c[1] = gg[0] | (pp[0] & c[0]);
        c[2] = gg[1] | (pp[1] & c[1]);
        c[3] = gg[2] | (pp[2] & c[2]);
        return pp ^ c;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_lcu_4.sv
// Four-way lookahead carry unit, used for both the nibble and the 16-bit group level.
// Produces the internal carries plus block propagate/generate for the next level.
module lcu_4
    import cla_adder_pipe_pkg::*;
(
    input  logic [LCU_SPAN-1:0] p,
    input  logic [LCU_SPAN-1:0] g,
    input  logic                c_in,
    output logic [LCU_SPAN-1:1] c,
    output logic                p_blk,
    output logic                g_blk
);

    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);

    assign p_blk = &p;
    assign g_blk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined WIDTH-bit add/subtract with two-level carry lookahead and ALU flags.
// Stage 1 registers prepared operands; stage 2 registers sum and flags; valid/ready both sides.
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic             in_use_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned NNIB = WIDTH / NIBBLE;
    localparam int unsigned NGRP = WIDTH / GROUP_BITS;

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_c0;
    logic             adv2;
    logic             accept;

    assign adv2      = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c0    <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_sub ? ~in_b : in_b;
            s1_c0    <= in_sub ^ (in_use_cin & in_cin);
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    logic [NNIB-1:0]  nib_p;
    logic [NNIB-1:0]  nib_g;
    logic [NNIB-1:0]  nib_c;
    logic [WIDTH-1:0] sum_w;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_cin;

    for (genvar i = 0; i < NNIB; i++) begin : g_nib
        nib_pg_t pg;
        assign pg       = nibble_pg(s1_a[i*NIBBLE +: NIBBLE], s1_b[i*NIBBLE +: NIBBLE]);
        assign nib_p[i] = pg.p;
        assign nib_g[i] = pg.g;
        assign sum_w[i*NIBBLE +: NIBBLE] =
            nibble_sum(s1_a[i*NIBBLE +: NIBBLE], s1_b[i*NIBBLE +: NIBBLE], nib_c[i]);
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        logic [LCU_SPAN-1:1] c;
        lcu_4 u_lcu_l1 (
            .p    (nib_p[j*LCU_SPAN +: LCU_SPAN]),
            .g    (nib_g[j*LCU_SPAN +: LCU_SPAN]),
            .c_in (grp_cin[j]),
            .c    (c),
            .p_blk(grp_p[j]),
            .g_blk(grp_g[j])
        );
        assign nib_c[j*LCU_SPAN +: LCU_SPAN] = {c, grp_cin[j]};
    end

    logic [LCU_SPAN-1:0] l2_p_in;
    logic [LCU_SPAN-1:0] l2_g_in;
    logic [LCU_SPAN-1:1] l2_c;
    logic                l2_p;
    logic                l2_g;
    logic [LCU_SPAN:0]   l2_all;
    logic                cout_w;
    logic                c_msb_w;

    assign l2_p_in = LCU_SPAN'(grp_p);
    assign l2_g_in = LCU_SPAN'(grp_g);

    lcu_4 u_lcu_l2 (
        .p    (l2_p_in),
        .g    (l2_g_in),
        .c_in (s1_c0),
        .c    (l2_c),
        .p_blk(l2_p),
        .g_blk(l2_g)
    );

    // Unused upper group slots have p=g=0, so every carry above the real MSB
    // group is 0 and OR-ing them yields exactly the carry out of bit WIDTH-1.
    assign l2_all  = {l2_g | (l2_p & s1_c0), l2_c, s1_c0};
    assign grp_cin = l2_all[NGRP-1:0];
    assign cout_w  = |l2_all[LCU_SPAN:NGRP];

    // Carry into the MSB recovered from sum = a ^ b ^ carry_in.
    assign c_msb_w = sum_w[WIDTH-1] ^ s1_a[WIDTH-1] ^ s1_b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            out_sum  <= sum_w;
            out_cout <= cout_w;
            out_ovf  <= cout_w ^ c_msb_w;
            out_zero <= ~|sum_w;
            out_neg  <= sum_w[WIDTH-1];
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: directed edge cases, reset, backpressure, random stream.
module tb_cla_adder_pipe;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic         use_cin;
        res_t         exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         in_use_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cla_adder_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .in_use_cin(in_use_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin, input logic use_cin);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   r;
        res_t         e;
        be     = sub ? ~b : b;
        c0     = sub ? ~(use_cin & cin) : (use_cin & cin);
        r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        e.zero = (r[W-1:0] == '0);
        e.neg  = r[W-1];
        return e;
    endfunction

    // Called at a negedge; drives one cycle, records handshakes, returns at the next negedge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic use_cin, input logic ordy,
                        output logic acc, output logic fired, output logic ov, output res_t got);
        in_valid   = iv;
        in_a       = a;
        in_b       = b;
        in_sub     = sub;
        in_cin     = cin;
        in_use_cin = use_cin;
        out_ready  = ordy;
        #1;
        acc   = in_valid & in_ready;
        fired = out_valid & out_ready;
        ov    = out_valid;
        got   = {out_sum, out_cout, out_ovf, out_zero, out_neg};
        if (acc) sb.push_back(model(a, b, sub, cin, use_cin));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic acc, fired, ov;
        res_t got;
        int   stale;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_tests++;
        if ({out_sum, out_cout, out_ovf, out_zero, out_neg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sum=%h c=%b v=%b z=%b n=%b exp all 0",
                     out_sum, out_cout, out_ovf, out_zero, out_neg);
        end
        @(negedge clk);
        step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, acc, fired, ov, got);
        step(1'b1, 32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, acc, fired, ov, got);
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_prefill: out_valid got %b exp 1", out_valid); end
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_a       = 32'hDEAD_BEEF;
        out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b exp 1", in_ready); end
        n_tests++;
        if (out_sum !== '0) begin n_fail++; $display("FAIL midreset_sum: got %h exp 0", out_sum); end
        sb.delete();
        @(negedge clk);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc, fired, ov, got);
            if (ov) stale++;
        end
        n_tests++;
        if (stale !== 0) begin n_fail++; $display("FAIL midreset_stale_beats: got %0d exp 0", stale); end
    endtask

    task automatic test_directed();
        vec_t v[8];
        logic acc, fired, ov;
        res_t got, exp;
        int   lat;
        v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
        v[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        v[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
        v[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b1, '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0}};
        v[5] = '{32'h0FFF_FFFF, 32'hF000_0000, 1'b0, 1'b1, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        v[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        v[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int k = 0; k < 8; k++) begin
            step(1'b1, v[k].a, v[k].b, v[k].sub, v[k].cin, v[k].use_cin, 1'b1, acc, fired, ov, got);
            n_tests++;
            if (acc !== 1'b1) begin n_fail++; $display("FAIL directed%0d_accept: got %b exp 1", k, acc); end
            lat   = 0;
            fired = 1'b0;
            for (int c = 1; c <= 8 && !fired; c++) begin
                step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc, fired, ov, got);
                if (fired) lat = c;
            end
            n_tests++;
            if (lat !== 2) begin n_fail++; $display("FAIL directed%0d_latency: got %0d exp 2", k, lat); end
            if (fired) begin
                n_tests++;
                if (got !== v[k].exp) begin
                    n_fail++;
                    $display("FAIL directed%0d_const: got %h/%b%b%b%b exp %h/%b%b%b%b", k,
                             got.sum, got.cout, got.ovf, got.zero, got.neg,
                             v[k].exp.sum, v[k].exp.cout, v[k].exp.ovf, v[k].exp.zero, v[k].exp.neg);
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    n_tests++;
                    if (got !== exp) begin n_fail++; $display("FAIL directed%0d_model: got %h exp %h", k, got, exp); end
                end
            end
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a[3];
        logic [W-1:0] b[3];
        logic         acc, fired, ov;
        res_t         got, held, exp;
        int           idx, seen, nrecv, first_fire, last_fire;
        a[0] = 32'h1111_1111; b[0] = 32'h0000_0001;
        a[1] = 32'h2222_2222; b[1] = 32'h0000_0002;
        a[2] = 32'h3333_3333; b[2] = 32'h0000_0003;
        idx  = 0;
        seen = 0;
        held = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(1'b1, a[idx], b[idx], 1'b0, 1'b0, 1'b0, 1'b0, acc, fired, ov, got);
            n_tests++;
            if (acc !== (idx < 2)) begin
                n_fail++;
                $display("FAIL bp_in_ready_c%0d: got %b exp %b", cyc, acc, (idx < 2));
            end
            if (cyc >= 2) begin
                n_tests++;
                if (!ov || (seen && got !== held)) begin
                    n_fail++;
                    $display("FAIL bp_hold_c%0d: got v=%b %h exp v=1 %h", cyc, ov, got, held);
                end
                if (!seen) begin held = got; seen = 1; end
            end
            if (acc) idx++;
        end
        nrecv      = 0;
        first_fire = -1;
        last_fire  = -1;
        for (int cyc = 0; cyc < 10 && nrecv < 3; cyc++) begin
            step(idx < 3, a[idx < 3 ? idx : 0], b[idx < 3 ? idx : 0], 1'b0, 1'b0, 1'b0, 1'b1,
                 acc, fired, ov, got);
            if (acc) idx++;
            if (fired) begin
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_beat: got %h exp none", got.sum);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL bp_order%0d: got %h exp %h", nrecv, got, exp); end
                end
                nrecv++;
            end
        end
        n_tests++;
        if (nrecv !== 3 || first_fire !== 0 || last_fire !== 2) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats in cycles %0d..%0d exp 3 in 0..2", nrecv, first_fire, last_fire);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         sub, cin, use_cin;
        logic         acc, fired, ov;
        res_t         got, exp;
        int           sent, recv, errs, extra, cyc;
        sent = 0; recv = 0; errs = 0; extra = 0; cyc = 0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); use_cin = 1'($urandom);
        while ((sent < 1000 || sb.size() > 0) && cyc < 20000) begin
            step((sent < 1000) && ($urandom_range(0, 9) < 8), a, b, sub, cin, use_cin,
                 (sent >= 1000) || ($urandom_range(0, 9) < 7), acc, fired, ov, got);
            cyc++;
            if (fired) begin
                recv++;
                if (sb.size() == 0) begin
                    extra++;
                end else begin
                    exp = sb.pop_front();
                    n_tests++;
                    if (got !== exp) begin
                        n_fail++;
                        errs++;
                        if (errs <= 5) $display("FAIL rand_beat%0d: got %h exp %h", recv, got, exp);
                    end
                end
            end
            if (acc) begin
                sent++;
                case ($urandom_range(0, 5))
                    0:       a = 32'hFFFF_FFFF;
                    1:       a = 32'h7FFF_FFFF;
                    2:       a = 32'h8000_0000;
                    default: a = $urandom;
                endcase
                b       = ($urandom_range(0, 4) == 0) ? 32'(1) : 32'($urandom);
                sub     = 1'($urandom);
                cin     = 1'($urandom);
                use_cin = 1'($urandom);
            end
        end
        n_tests++;
        if (recv !== 1000 || extra !== 0 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d recv %0d extra %0d pending exp 1000/0/0", recv, extra, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_sub     = 1'b0;
        in_cin     = 1'b0;
        in_use_cin = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
